// File: rtl/biquad_tdm_if.sv
// biquad_tdm_if: signal bundle for the time-multiplexed biquad.
//
// Groups the frame handshake, the filtered output bus and the coefficient
// write port. The filter block connects through the slave modport; the
// frame source / coefficient writer connects through the master modport.
//
// Handshake: a frame transfers on a clk_48 edge where in_valid and in_ready
// are both high. The source holds in_valid, filter and in_data stable until
// that edge. out_valid is a one-cycle pulse; out_data and sat stay valid
// until the next pulse. A coefficient write commits on an edge where
// coef_ack is high; without coef_ack the write is dropped and must be retried.
//
// Signals:
//   filter      requested coefficient set, sampled on frame accept
//   in_valid    frame valid (source -> filter)
//   in_ready    filter idle, can accept a frame
//   in_data     CH samples, channel c in bits [c*W +: W]
//   out_valid   one-cycle pulse, out_data/sat updated
//   out_data    filtered frame, same packing as in_data
//   sat         per-channel clip flag for the last frame
//   coef_we     coefficient write strobe
//   coef_set    target set
//   coef_idx    0=b0, 1=b1, 2=b2, 3=a1, 4=a2
//   coef_wdata  signed fixed-point coefficient value
//   coef_ack    high in the cycle a write commits
interface biquad_tdm_if #(
    parameter int W    = 16,
    parameter int CH   = 2,
    parameter int CW   = 32,
    parameter int NSET = 8
);
    localparam int SW = (NSET > 1) ? $clog2(NSET) : 1;

    logic [SW-1:0]   filter;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] in_data;
    logic            out_valid;
    logic [CH*W-1:0] out_data;
    logic [CH-1:0]   sat;
    logic            coef_we;
    logic [SW-1:0]   coef_set;
    logic [2:0]      coef_idx;
    logic [CW-1:0]   coef_wdata;
    logic            coef_ack;

    modport master (
        output filter, in_valid, in_data, coef_we, coef_set, coef_idx, coef_wdata,
        input  in_ready, out_valid, out_data, sat, coef_ack
    );

    modport slave (
        input  filter, in_valid, in_data, coef_we, coef_set, coef_idx, coef_wdata,
        output in_ready, out_valid, out_data, sat, coef_ack
    );
endinterface

// File: rtl/biquad_tdm.sv
// biquad_tdm: time-multiplexed multi-channel direct-form-I biquad.
//
// One signed multiplier is shared by all channels. Each channel takes five
// MAC cycles (x0, x1, x2, y1, y2 against b0, b1, b2, a1, a2) and one STORE
// cycle that rounds down, saturates and shifts the history. Feedback signs
// are folded into a1/a2, so the sum is always y = b0*x0 + b1*x1 + b2*x2 +
// a1*y1 + a2*y2, shifted right arithmetically by FRAC once at the end.
//
// Coefficients sit in NSET runtime-writable sets. A frame picks its set via
// filter (out-of-range selects set 0). With CLR_ON_CHANGE, switching sets
// between frames wipes every channel's history so no residue of the old
// response leaks into the new one.
//
// Ports:
//   clk_48       system clock
//   reset_n      asynchronous active-low reset
//   bus          biquad_tdm_if slave modport (frame in/out, coefficient port)
//   dbg_state_o  current FSM state (IDLE=0, MAC=1, STORE=2, DONE=3)
module biquad_tdm #(
    parameter int W             = 16,
    parameter int CH            = 2,
    parameter int CW            = 32,
    parameter int FRAC          = 30,
    parameter int NSET          = 8,
    parameter bit CLR_ON_CHANGE = 1'b1,
    parameter int ACCW          = CW + W + 4
) (
    input  logic             clk_48,
    input  logic             reset_n,
    biquad_tdm_if.slave      bus,
    output logic [1:0]       dbg_state_o
);
    localparam int SW  = (NSET > 1) ? $clog2(NSET) : 1;
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW  = CW + W;

    localparam logic signed [CW-1:0]   ONE_Q = CW'(1) << FRAC;
    localparam logic signed [ACCW-1:0] Y_MAX = (ACCW'(1) <<< (W - 1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     k_q, k_d;
    logic [CHW-1:0] ch_q, ch_d;

    logic signed [CW-1:0] coef_q [NSET][5];

    logic signed [W-1:0] x0_q [CH];
    logic signed [W-1:0] x1_q [CH];
    logic signed [W-1:0] x2_q [CH];
    logic signed [W-1:0] y1_q [CH];
    logic signed [W-1:0] y2_q [CH];
    logic [CH-1:0]       satb_q;

    // act_q doubles as "previous frame's set": it only changes on accept,
    // so at the accept edge it still holds the set of the frame before.
    logic [SW-1:0]          act_q;
    logic signed [ACCW-1:0] acc_q;
    logic [CH*W-1:0]        out_data_q;
    logic [CH-1:0]          sat_q;

    logic                   accept;
    logic                   busy;
    logic                   last_ch;
    logic                   clr_hist;
    logic                   coef_commit;
    logic [SW-1:0]          act_sel;
    logic signed [W-1:0]    opnd_x;
    logic signed [CW-1:0]   opnd_c;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_sh;
    logic                   clip_hi;
    logic                   clip_lo;
    logic signed [W-1:0]    yq;

    assign accept   = bus.in_valid && (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign last_ch  = (ch_q == CHW'(CH - 1));
    assign act_sel  = (int'(bus.filter) >= NSET) ? '0 : bus.filter;
    assign clr_hist = CLR_ON_CHANGE && (act_sel != act_q);

    // A set in use by the running frame is locked, and so is the set a
    // frame is about to start with on this very edge.
    assign coef_commit = bus.coef_we
                      && (bus.coef_idx <= 3'd4)
                      && (int'(bus.coef_set) < NSET)
                      && !(busy && (bus.coef_set == act_q))
                      && !(accept && (bus.coef_set == act_sel));

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_data_q;
    assign bus.sat       = sat_q;
    assign bus.coef_ack  = coef_commit;
    assign dbg_state_o   = state_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    k_d     = '0;
                    ch_d    = '0;
                end
            end
            MAC: begin
                if (k_q == 3'd4) begin
                    state_d = STORE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            STORE: begin
                if (last_ch) begin
                    state_d = DONE;
                end else begin
                    state_d = MAC;
                    k_d     = '0;
                    ch_d    = ch_q + CHW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- MAC operand select ----------------
    always_comb begin
        opnd_x = x0_q[ch_q];
        opnd_c = coef_q[act_q][0];
        case (k_q)
            3'd1: begin
                opnd_x = x1_q[ch_q];
                opnd_c = coef_q[act_q][1];
            end
            3'd2: begin
                opnd_x = x2_q[ch_q];
                opnd_c = coef_q[act_q][2];
            end
            3'd3: begin
                opnd_x = y1_q[ch_q];
                opnd_c = coef_q[act_q][3];
            end
            3'd4: begin
                opnd_x = y2_q[ch_q];
                opnd_c = coef_q[act_q][4];
            end
            default: ;
        endcase
    end

    assign prod     = PW'(opnd_c) * PW'(opnd_x);
    assign prod_ext = ACCW'(prod);

    // Floor shift, then clip to the sample range.
    assign acc_sh  = acc_q >>> FRAC;
    assign clip_hi = (acc_sh > Y_MAX);
    assign clip_lo = (acc_sh < Y_MIN);
    assign yq      = clip_hi ? Y_MAX[W-1:0] :
                     clip_lo ? Y_MIN[W-1:0] : acc_sh[W-1:0];

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) begin
                x0_q[c] <= '0;
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
            end
            satb_q     <= '0;
            act_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            sat_q      <= '0;
        end else begin
            if (accept) begin
                act_q <= act_sel;
                for (int c = 0; c < CH; c++) begin
                    x0_q[c] <= bus.in_data[c*W +: W];
                    if (clr_hist) begin
                        x1_q[c] <= '0;
                        x2_q[c] <= '0;
                        y1_q[c] <= '0;
                        y2_q[c] <= '0;
                    end
                end
            end

            if (state_q == MAC) begin
                acc_q <= ((k_q == 3'd0) ? '0 : acc_q) + prod_ext;
            end

            if (state_q == STORE) begin
                for (int c = 0; c < CH; c++) begin
                    if (c == int'(ch_q)) begin
                        x2_q[c]   <= x1_q[c];
                        x1_q[c]   <= x0_q[c];
                        y2_q[c]   <= y1_q[c];
                        y1_q[c]   <= yq;
                        satb_q[c] <= clip_hi || clip_lo;
                    end
                end
                // Earlier channels' results already sit in y1_q; the last
                // channel's result is still on yq this cycle. Publishing all
                // of them together keeps out_data stable between pulses.
                if (last_ch) begin
                    for (int c = 0; c < CH; c++) begin
                        if (c == int'(ch_q)) begin
                            out_data_q[c*W +: W] <= yq;
                            sat_q[c]             <= clip_hi || clip_lo;
                        end else begin
                            out_data_q[c*W +: W] <= y1_q[c];
                            sat_q[c]             <= satb_q[c];
                        end
                    end
                end
            end
        end
    end

    // ---------------- Coefficient bank ----------------
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NSET; s++) begin
                for (int i = 0; i < 5; i++) begin
                    coef_q[s][i] <= (i == 0) ? ONE_Q : '0;
                end
            end
        end else if (coef_commit) begin
            coef_q[bus.coef_set][bus.coef_idx] <= bus.coef_wdata;
        end
    end
endmodule
